// File: rtl/idli_pkg.sv
// Shared types and opcodes for the idli SQI responder.
package idli_pkg;

  typedef logic [3:0] sqi_data_t;

  typedef enum logic [3:0] {
    IDLE,
    INSTR,
    ADDR,
    DUMMY,
    RDATA,
    WDATA,
    MODE_RD,
    MODE_WR,
    IGNORE
  } sqi_resp_state_t;

  localparam logic [7:0] SQI_OP_READ  = 8'h03;
  localparam logic [7:0] SQI_OP_WRITE = 8'h02;
  localparam logic [7:0] SQI_OP_RDMR  = 8'h05;
  localparam logic [7:0] SQI_OP_WRMR  = 8'h01;

endpackage

// File: rtl/idli_sqi_resp_mem_m.sv
// Byte-wide backing store for the SQI responder: one SQI write/read port and a
// backdoor port; on a same-address, same-cycle collision the SQI write lands.
module idli_sqi_resp_mem_m #(
  parameter  int unsigned MEM_BYTES = 1024,
  localparam int unsigned AW        = $clog2(MEM_BYTES)
) (
  input  logic          clk,
  input  logic          sqi_we,
  input  logic [AW-1:0] sqi_addr,
  input  logic [7:0]    sqi_wdata,
  output logic [7:0]    sqi_rdata,
  input  logic          bd_we,
  input  logic [AW-1:0] bd_addr,
  input  logic [7:0]    bd_wdata,
  output logic [7:0]    bd_rdata
);

  logic [7:0] mem [MEM_BYTES];

  // Contents survive reset; SQI write ordered last so it wins a collision.
  always_ff @(posedge clk) begin
    if (bd_we)  mem[bd_addr]  <= bd_wdata;
    if (sqi_we) mem[sqi_addr] <= sqi_wdata;
  end

  assign sqi_rdata = mem[sqi_addr];
  assign bd_rdata  = mem[bd_addr];

endmodule

// File: rtl/idli_sqi_resp_m.sv
// SQI quad-SRAM responder (23LC1024-style) on one chip select.
// Optional mode register (byte/page/sequential) enabled by IDLI_SQI_RESP_MODE_REG_EN.
module idli_sqi_resp_m
  import idli_pkg::*;
#(
  parameter  int unsigned MEM_BYTES  = 1024,
  parameter  int unsigned PAGE_BYTES = 32,
  localparam int unsigned AW         = $clog2(MEM_BYTES),
  localparam int unsigned PW         = $clog2(PAGE_BYTES)
) (
  input  logic          i_sqi_gck,
  input  logic          i_sqi_rst,
  input  logic          i_sqi_sck,
  input  logic          i_sqi_cs,
  input  sqi_data_t     i_sqi_sio,
  output sqi_data_t     o_sqi_sio,
  output logic          o_sqi_oe,
  input  logic          i_bd_we,
  input  logic [AW-1:0] i_bd_addr,
  input  logic [7:0]    i_bd_data,
  output logic [7:0]    o_bd_data
);

  sqi_resp_state_t state;
  logic            sck_q;
  logic [2:0]      nib_cnt;
  logic [7:0]      op;
  logic [AW-1:0]   addr;
  logic [3:0]      wr_hi;
  logic            half;
  logic [7:0]      rd_byte;
  logic            rise;
  logic            fall;
  logic            sqi_we;
  logic            byte_mode;
  logic            page_mode;
  logic [AW-1:0]   addr_next;

`ifdef IDLI_SQI_RESP_MODE_REG_EN
  logic [7:0] mode;
  assign byte_mode = (mode[7:6] == 2'b00);
  assign page_mode = (mode[7:6] == 2'b10);
`else
  assign byte_mode = 1'b0;
  assign page_mode = 1'b0;
`endif

  assign rise   = i_sqi_sck & ~sck_q;
  assign fall   = ~i_sqi_sck & sck_q;
  assign sqi_we = ~i_sqi_cs & rise & half & (state == WDATA);

  // Page mode wraps within the current page, otherwise wrap the whole array.
  assign addr_next = page_mode ? {addr[AW-1:PW], addr[PW-1:0] + PW'(1)}
                               : addr + AW'(1);

  function automatic sqi_resp_state_t decode_op(input logic [7:0] opc);
    case (opc)
      SQI_OP_READ, SQI_OP_WRITE: return ADDR;
`ifdef IDLI_SQI_RESP_MODE_REG_EN
      SQI_OP_RDMR: return MODE_RD;
      SQI_OP_WRMR: return MODE_WR;
`endif
      default: return IGNORE;
    endcase
  endfunction

  always_ff @(posedge i_sqi_gck or posedge i_sqi_rst) begin
    if (i_sqi_rst) begin
      state     <= IDLE;
      sck_q     <= 1'b0;
      nib_cnt   <= 3'd0;
      op        <= 8'h00;
      addr      <= '0;
      wr_hi     <= 4'h0;
      half      <= 1'b0;
      o_sqi_sio <= 4'h0;
      o_sqi_oe  <= 1'b0;
`ifdef IDLI_SQI_RESP_MODE_REG_EN
      mode      <= 8'h40;
`endif
    end else begin
      sck_q <= i_sqi_sck;
      if (i_sqi_cs) begin
        state     <= IDLE;
        nib_cnt   <= 3'd0;
        half      <= 1'b0;
        o_sqi_oe  <= 1'b0;
        o_sqi_sio <= 4'h0;
      end else begin
        case (state)
          IDLE: begin
            state   <= INSTR;
            nib_cnt <= 3'd0;
          end
          INSTR: if (rise) begin
            op <= {op[3:0], i_sqi_sio};
            if (nib_cnt == 3'd1) begin
              nib_cnt <= 3'd0;
              half    <= 1'b0;
              state   <= decode_op({op[3:0], i_sqi_sio});
            end else begin
              nib_cnt <= nib_cnt + 3'd1;
            end
          end
          // Shifting into the kept address bits drops the unused upper nibbles.
          ADDR: if (rise) begin
            addr <= {addr[AW-5:0], i_sqi_sio};
            if (nib_cnt == 3'd5) begin
              nib_cnt <= 3'd0;
              half    <= 1'b0;
              state   <= (op == SQI_OP_READ) ? DUMMY : WDATA;
            end else begin
              nib_cnt <= nib_cnt + 3'd1;
            end
          end
          DUMMY: begin
            if (rise) begin
              nib_cnt <= nib_cnt + 3'd1;
            end else if (fall && nib_cnt == 3'd2) begin
              state     <= RDATA;
              nib_cnt   <= 3'd0;
              o_sqi_sio <= rd_byte[7:4];
              o_sqi_oe  <= 1'b1;
              half      <= 1'b1;
            end
          end
          // nib_cnt == 3 marks a finished byte in byte mode; the next fall releases.
          RDATA: if (fall) begin
            if (nib_cnt == 3'd3) begin
              o_sqi_oe  <= 1'b0;
              o_sqi_sio <= 4'h0;
              state     <= IGNORE;
            end else if (half) begin
              o_sqi_sio <= rd_byte[3:0];
              addr      <= addr_next;
              half      <= 1'b0;
              if (byte_mode) nib_cnt <= 3'd3;
            end else begin
              o_sqi_sio <= rd_byte[7:4];
              half      <= 1'b1;
            end
          end
          WDATA: if (rise) begin
            if (!half) begin
              wr_hi <= i_sqi_sio;
              half  <= 1'b1;
            end else begin
              addr <= addr_next;
              half <= 1'b0;
              if (byte_mode) state <= IGNORE;
            end
          end
`ifdef IDLI_SQI_RESP_MODE_REG_EN
          MODE_RD: begin
            if (rise && nib_cnt < 3'd2) begin
              nib_cnt <= nib_cnt + 3'd1;
            end else if (fall && nib_cnt == 3'd2) begin
              o_sqi_oe  <= 1'b1;
              o_sqi_sio <= half ? mode[3:0] : mode[7:4];
              half      <= ~half;
            end
          end
          MODE_WR: if (rise) begin
            if (!half) begin
              wr_hi <= i_sqi_sio;
              half  <= 1'b1;
            end else begin
              mode  <= {wr_hi, i_sqi_sio};
              half  <= 1'b0;
              state <= IGNORE;
            end
          end
`endif
          default: state <= IGNORE;
        endcase
      end
    end
  end

  idli_sqi_resp_mem_m #(.MEM_BYTES(MEM_BYTES)) u_mem (
    .clk       (i_sqi_gck),
    .sqi_we    (sqi_we),
    .sqi_addr  (addr),
    .sqi_wdata ({wr_hi, i_sqi_sio}),
    .sqi_rdata (rd_byte),
    .bd_we     (i_bd_we),
    .bd_addr   (i_bd_addr),
    .bd_wdata  (i_bd_data),
    .bd_rdata  (o_bd_data)
  );

endmodule
